led_mode_ctrl: RTL and testbench
================================

Name: led_mode_ctrl

Overview:
Controller that sequences and shares the board LEDs between two LED pattern datapaths: the shift datapath and the flash datapath.
- Contains a speed-selectable tick prescaler that generates the datapaths' valid strobes.
- A pushbutton-driven mode FSM decides which datapath owns the LEDs and receives ticks.
- On every mode change it issues a one-cycle restart pulse so the incoming datapath starts from its reset pattern.

Parameters:
NB_LED, 4, LED vector width
NB_COUNTER, 32, prescaler counter width
LIMIT_0, 2**(NB_COUNTER-8)-1, terminal count for speed 0 (slowest)
LIMIT_1, 2**(NB_COUNTER-9)-1, terminal count for speed 1
LIMIT_2, 2**(NB_COUNTER-10)-1, terminal count for speed 2
LIMIT_3, 2**(NB_COUNTER-11)-1, terminal count for speed 3 (fastest)
N_AUTO, 8, ticks per automatic mode rotation (used only with LED_MODE_AUTO_EN)

Ports:
clock  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_enable  in  1  prescaler run enable (switch 0)
i_speed  in  2  speed select, indexes LIMIT_0..LIMIT_3
i_dir  in  1  shift direction request
i_btn_mode  in  1  raw mode pushbutton, asynchronous to clock
i_led_shift  in  NB_LED  LED vector from shift datapath
i_led_flash  in  NB_LED  LED vector from flash datapath
o_valid_shift  out  1  tick to shift datapath
o_valid_flash  out  1  tick to flash datapath
o_dir  out  1  registered direction to shift datapath
o_restart  out  1  one-cycle synchronous restart to both datapaths
o_mode  out  2  current FSM state
o_led  out  NB_LED  LED vector driven to the board

Behaviour:
- Reset (i_reset=0), asynchronous:
  - counter=0, state=ST_SHIFT.
  - o_valid_shift=0, o_valid_flash=0, o_dir=0, o_restart=0.
  - o_mode=2'b00, o_led=0.
  - Button synchronizer and edge detector cleared.
- Prescaler:
  - While i_enable=1, counter increments every cycle.
  - When counter >= LIMIT[i_speed], counter <= 0 and tick is raised.
  - Tick is registered: the o_valid_* pulse is high the cycle after the terminal count. Period is LIMIT+1 cycles.
  - Using >= means a speed change to a smaller limit wraps on the next cycle; it never overflows.
  - While i_enable=0, the counter holds and no ticks are generated.
- Button path:
  - 2-flop synchronizer, then rising-edge detect, giving a 1-cycle btn_evt.
  - Total latency from pin to btn_evt is 3 cycles.
  - Holding the button produces exactly one event.
- FSM states: ST_SHIFT=00, ST_FLASH=01, ST_SWITCH=10. Code 11 is illegal and recovers to ST_SHIFT.
  - ST_SHIFT:
    - btn_evt: next_target=FLASH, go to ST_SWITCH.
    - Otherwise tick drives o_valid_shift.
  - ST_FLASH:
    - btn_evt: next_target=SHIFT, go to ST_SWITCH.
    - Otherwise tick drives o_valid_flash.
  - ST_SWITCH (exactly 1 cycle):
    - o_restart=1 and counter cleared to 0.
    - No valid asserted; btn_evt ignored.
    - Next state is next_target.
- Simultaneous events:
  - Tick and btn_evt in the same cycle: the tick is still delivered to the current owner, and the FSM switches.
  - Tick due during ST_SWITCH is discarded because the counter is cleared.
- o_dir: registered copy of i_dir every cycle, 1-cycle latency, independent of mode.
- o_led (registered):
  - ST_SHIFT: i_led_shift.
  - ST_FLASH: i_led_flash.
  - ST_SWITCH: all zeros.
- o_mode: equals the state register.
- Reset mid-operation: all state is cleared immediately. The first tick after reset release comes LIMIT[i_speed]+2 cycles later (assuming i_enable=1).

Optional Feature:
LED_MODE_AUTO_EN
- Defined:
  - A tick counter counts ticks delivered in ST_SHIFT or ST_FLASH.
  - On the N_AUTO-th tick, the FSM enters ST_SWITCH toward the other mode, exactly as for btn_evt.
  - The tick counter clears on any mode change, including button-driven ones, and on reset.
- Not defined: no tick counter is built; mode changes only on btn_evt.

Test Plan:
- Setup for all scenarios: LIMIT_0..3 = 3, 7, 15, 31 and NB_LED=4.
- Reset then release, i_enable=1, i_speed=0 -> o_valid_shift pulses every 4 cycles, first pulse 5 cycles after release; o_valid_flash=0; o_mode=00.
- i_speed 3->0 while counter=20 -> the next cycle wraps; tick the following cycle; then a period of 4.
- Button held high for 10 cycles in ST_SHIFT -> exactly one o_restart pulse 4 cycles after press; o_led=0 during it; o_mode goes 00 -> 10 -> 01; ticks now appear on o_valid_flash only.
- i_enable=0 for 20 cycles with counter at 2 -> no valids; on re-enable, the tick arrives after 2 more cycles (counter resumes from 2).
- Button edge in the same cycle as the terminal count in ST_FLASH -> the o_valid_flash pulse is delivered; the FSM goes to ST_SWITCH, then ST_SHIFT.
- LED_MODE_AUTO_EN defined, N_AUTO=8 -> after 8 shift ticks the FSM auto-switches to FLASH; a button press mid-count resets the auto count.

Source files
------------

// File: rtl/led_mode_ctrl.sv
// rtl/led_mode_ctrl.sv - LED owner FSM with tick prescaler and mode pushbutton
// Optional build macro LED_MODE_AUTO_EN adds automatic mode rotation every N_AUTO ticks.
module led_mode_ctrl #(
    parameter int unsigned               NB_LED     = 4,
    parameter int unsigned               NB_COUNTER = 32,
    parameter logic [NB_COUNTER-1:0]     LIMIT_0    = NB_COUNTER'((64'd1 << (NB_COUNTER - 8)) - 64'd1),
    parameter logic [NB_COUNTER-1:0]     LIMIT_1    = NB_COUNTER'((64'd1 << (NB_COUNTER - 9)) - 64'd1),
    parameter logic [NB_COUNTER-1:0]     LIMIT_2    = NB_COUNTER'((64'd1 << (NB_COUNTER - 10)) - 64'd1),
    parameter logic [NB_COUNTER-1:0]     LIMIT_3    = NB_COUNTER'((64'd1 << (NB_COUNTER - 11)) - 64'd1),
    parameter int unsigned               N_AUTO     = 8
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [1:0]        i_speed,
    input  logic              i_dir,
    input  logic              i_btn_mode,
    input  logic [NB_LED-1:0] i_led_shift,
    input  logic [NB_LED-1:0] i_led_flash,
    output logic              o_valid_shift,
    output logic              o_valid_flash,
    output logic              o_dir,
    output logic              o_restart,
    output logic [1:0]        o_mode,
    output logic [NB_LED-1:0] o_led
);

    typedef enum logic [1:0] {
        ST_SHIFT  = 2'b00,
        ST_FLASH  = 2'b01,
        ST_SWITCH = 2'b10
    } state_t;

    state_t                  state_q;
    state_t                  target_q;
    logic [NB_COUNTER-1:0]   counter_q;
    logic [NB_COUNTER-1:0]   counter_d;
    logic [NB_COUNTER-1:0]   limit;
    logic                    tick_q;
    logic                    tick_d;
    logic [2:0]              sync_q;
    logic                    btn_evt_q;
    logic                    dir_q;
    logic                    valid_shift_q;
    logic                    valid_flash_q;
    logic                    restart_q;
    logic [NB_LED-1:0]       led_q;
    logic                    auto_evt;

    always_comb begin
        case (i_speed)
            2'd0:    limit = LIMIT_0;
            2'd1:    limit = LIMIT_1;
            2'd2:    limit = LIMIT_2;
            default: limit = LIMIT_3;
        endcase
    end

    // >= (not ==) lets a switch to a shorter period wrap at once instead of overflowing
    always_comb begin
        counter_d = counter_q;
        tick_d    = 1'b0;
        if (state_q == ST_SWITCH) begin
            counter_d = '0;
        end else if (i_enable) begin
            if (counter_q >= limit) begin
                counter_d = '0;
                tick_d    = 1'b1;
            end else begin
                counter_d = counter_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            counter_q <= '0;
            tick_q    <= 1'b0;
            sync_q    <= '0;
            btn_evt_q <= 1'b0;
            dir_q     <= 1'b0;
        end else begin
            counter_q <= counter_d;
            tick_q    <= tick_d;
            sync_q    <= {sync_q[1:0], i_btn_mode};
            btn_evt_q <= sync_q[1] & ~sync_q[2];
            dir_q     <= i_dir;
        end
    end

`ifdef LED_MODE_AUTO_EN
    localparam int unsigned AUTO_W = $clog2(N_AUTO + 1);
    logic [AUTO_W-1:0] auto_cnt_q;

    assign auto_evt = tick_q && (state_q == ST_SHIFT || state_q == ST_FLASH)
                      && (auto_cnt_q == AUTO_W'(N_AUTO - 1));

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            auto_cnt_q <= '0;
        end else if (state_q != ST_SHIFT && state_q != ST_FLASH) begin
            auto_cnt_q <= '0;
        end else if (btn_evt_q || auto_evt) begin
            auto_cnt_q <= '0;
        end else if (tick_q) begin
            auto_cnt_q <= auto_cnt_q + 1'b1;
        end
    end
`else
    assign auto_evt = 1'b0;
`endif

    // Outputs are registered alongside the state so o_mode, o_led and o_restart line up.
    // A tick landing with a mode event still goes to the owner that earned it.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q       <= ST_SHIFT;
            target_q      <= ST_SHIFT;
            valid_shift_q <= 1'b0;
            valid_flash_q <= 1'b0;
            restart_q     <= 1'b0;
            led_q         <= '0;
        end else begin
            valid_shift_q <= 1'b0;
            valid_flash_q <= 1'b0;
            restart_q     <= 1'b0;
            case (state_q)
                ST_SHIFT: begin
                    valid_shift_q <= tick_q;
                    if (btn_evt_q || auto_evt) begin
                        target_q  <= ST_FLASH;
                        state_q   <= ST_SWITCH;
                        restart_q <= 1'b1;
                        led_q     <= '0;
                    end else begin
                        led_q     <= i_led_shift;
                    end
                end
                ST_FLASH: begin
                    valid_flash_q <= tick_q;
                    if (btn_evt_q || auto_evt) begin
                        target_q  <= ST_SHIFT;
                        state_q   <= ST_SWITCH;
                        restart_q <= 1'b1;
                        led_q     <= '0;
                    end else begin
                        led_q     <= i_led_flash;
                    end
                end
                ST_SWITCH: begin
                    state_q <= target_q;
                    led_q   <= (target_q == ST_FLASH) ? i_led_flash : i_led_shift;
                end
                default: begin
                    state_q <= ST_SHIFT;
                    led_q   <= i_led_shift;
                end
            endcase
        end
    end

    assign o_valid_shift = valid_shift_q;
    assign o_valid_flash = valid_flash_q;
    assign o_dir         = dir_q;
    assign o_restart     = restart_q;
    assign o_mode        = state_q;
    assign o_led         = led_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb/tb_led_mode_ctrl.sv - directed bench for led_mode_ctrl with short prescaler limits
module tb_led_mode_ctrl;

    logic       clock = 1'b0;
    logic       i_reset;
    logic       i_enable;
    logic [1:0] i_speed;
    logic       i_dir;
    logic       i_btn_mode;
    logic [3:0] i_led_shift;
    logic [3:0] i_led_flash;
    logic       o_valid_shift;
    logic       o_valid_flash;
    logic       o_dir;
    logic       o_restart;
    logic [1:0] o_mode;
    logic [3:0] o_led;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    led_mode_ctrl #(
        .NB_LED     (4),
        .NB_COUNTER (32),
        .LIMIT_0    (3),
        .LIMIT_1    (7),
        .LIMIT_2    (15),
        .LIMIT_3    (31),
        .N_AUTO     (8)
    ) dut (
        .clock         (clock),
        .i_reset       (i_reset),
        .i_enable      (i_enable),
        .i_speed       (i_speed),
        .i_dir         (i_dir),
        .i_btn_mode    (i_btn_mode),
        .i_led_shift   (i_led_shift),
        .i_led_flash   (i_led_flash),
        .o_valid_shift (o_valid_shift),
        .o_valid_flash (o_valid_flash),
        .o_dir         (o_dir),
        .o_restart     (o_restart),
        .o_mode        (o_mode),
        .o_led         (o_led)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        step();
        i_reset = 1'b1;
    endtask

    initial begin
        int ones;
        i_reset     = 1'b0;
        i_enable    = 1'b1;
        i_speed     = 2'd0;
        i_dir       = 1'b1;
        i_btn_mode  = 1'b0;
        i_led_shift = 4'b1010;
        i_led_flash = 4'b0101;

        // reset state
        step();
        check("rst valid_shift", o_valid_shift, 0);
        check("rst valid_flash", o_valid_flash, 0);
        check("rst dir", o_dir, 0);
        check("rst restart", o_restart, 0);
        check("rst mode", o_mode, 0);
        check("rst led", o_led, 0);

        // speed 0: first pulse 5 cycles after release, then every 4
        do_reset();
        for (int k = 1; k <= 13; k++) begin
            step();
            check($sformatf("A valid_shift k=%0d", k), o_valid_shift, (k >= 5 && (k - 5) % 4 == 0));
            check($sformatf("A valid_flash k=%0d", k), o_valid_flash, 0);
        end
        check("A mode", o_mode, 0);
        check("A led", o_led, 4'b1010);
        check("A dir", o_dir, 1);

        // speed 3 -> 0 with counter at 20
        i_speed = 2'd3;
        do_reset();
        for (int k = 1; k <= 26; k++) begin
            step();
            check($sformatf("B valid_shift k=%0d", k), o_valid_shift, (k == 22 || k == 26));
            if (k == 20) i_speed = 2'd0;
        end

        // enable pause with counter at 2
        i_speed = 2'd0;
        do_reset();
        step();
        step();
        i_enable = 1'b0;
        ones = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            ones += int'(o_valid_shift) + int'(o_valid_flash);
        end
        check("C paused valids", ones, 0);
        i_enable = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("C resume k=%0d", k), o_valid_shift, (k == 3));
        end

        // button held 10 cycles in SHIFT
        i_led_shift = 4'b0011;
        i_led_flash = 4'b1100;
        do_reset();
        i_btn_mode = 1'b1;
        ones = 0;
        for (int k = 1; k <= 22; k++) begin
            step();
            ones += int'(o_restart);
            check($sformatf("D restart k=%0d", k), o_restart, (k == 4));
            check($sformatf("D mode k=%0d", k), o_mode, (k < 4) ? 0 : (k == 4) ? 2 : 1);
            check($sformatf("D led k=%0d", k), o_led, (k < 4) ? 4'b0011 : (k == 4) ? 4'b0000 : 4'b1100);
            check($sformatf("D valid_shift k=%0d", k), o_valid_shift, 0);
            check($sformatf("D valid_flash k=%0d", k), o_valid_flash, (k >= 10 && (k - 10) % 4 == 0));
            if (k == 10) i_btn_mode = 1'b0;
        end
        check("D restart count", ones, 1);

        // button event coincides with a flash tick
        i_btn_mode = 1'b1;
        for (int k = 23; k <= 32; k++) begin
            step();
            if (k == 26) begin
                check("E valid_flash at switch", o_valid_flash, 1);
                check("E mode at switch", o_mode, 2);
                check("E restart at switch", o_restart, 1);
                check("E led at switch", o_led, 0);
            end else begin
                check($sformatf("E valid_flash k=%0d", k), o_valid_flash, 0);
            end
            if (k == 27) begin
                check("E mode after switch", o_mode, 0);
                check("E led after switch", o_led, 4'b0011);
                i_btn_mode = 1'b0;
            end
            check($sformatf("E valid_shift k=%0d", k), o_valid_shift, (k == 32));
        end

        // asynchronous reset mid-operation, then speed 1 first tick after 9 cycles
        #2;
        i_reset = 1'b0;
        #1;
        check("F async valid_shift", o_valid_shift, 0);
        check("F async led", o_led, 0);
        check("F async mode", o_mode, 0);
        check("F async dir", o_dir, 0);
        i_speed = 2'd1;
        step();
        i_reset = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            check($sformatf("F valid_shift k=%0d", k), o_valid_shift, (k == 9));
        end

`ifdef LED_MODE_AUTO_EN
        i_speed = 2'd0;
        do_reset();
        for (int k = 1; k <= 34; k++) begin
            step();
            if (k == 32) check("G mode before auto", o_mode, 0);
            if (k == 33) begin
                check("G mode auto switch", o_mode, 2);
                check("G eighth tick", o_valid_shift, 1);
            end
            if (k == 34) check("G mode flash", o_mode, 1);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
